// File: rtl/px_out_serializer.sv
// Output serializer: queues 24-bit pixel strobes in a small FIFO and emits them as
// 1 or 3 bytes (LSB first) over valid/ack. Define PX_SER_LAST_EN to add byte_last_o.
module px_out_serializer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_PIXEL_BITS = 24
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                select_i,
    input  logic                      px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
    output logic [7:0]                byte_o,
    output logic                      byte_valid_o,
    input  logic                      byte_ack_i,
    output logic                      fifo_full_o,
    output logic                      overflow_o,
`ifdef PX_SER_LAST_EN
    output logic                      byte_last_o,
`endif
    output logic                      busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = MAX_PIXEL_BITS + 2;
    localparam int NB = MAX_PIXEL_BITS / 8;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_reg, state_next;
    logic [AW-1:0]               wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]               rd_ptr_reg, rd_ptr_next;
    logic [AW:0]                 count_reg, count_next;
    logic [MAX_PIXEL_BITS-1:0]   shift_reg, shift_next;
    logic [1:0]                  nbytes_reg, nbytes_next;
    logic [1:0]                  idx_reg, idx_next;
    logic                        overflow_reg, overflow_next;

    logic [EW-1:0]               mem [FIFO_DEPTH];
    logic [EW-1:0]               rd_data;
    logic [MAX_PIXEL_BITS-1:0]   shifted;
    logic [1:0]                  nbytes_in;
    logic                        full, empty, push, pop, xfer, last_byte;

    assign full      = (count_reg == DEPTH_CNT);
    assign empty     = (count_reg == '0);
    assign push      = px_rdy_i && !full;
    assign nbytes_in = (select_i == 2'b11) ? 2'd3 : 2'd1;
    assign rd_data   = mem[rd_ptr_reg];
    assign xfer      = (state_reg == SEND) && byte_ack_i;
    assign last_byte = (idx_reg == (nbytes_reg - 2'd1));

    // Byte lanes move down one position per transfer; the top lane fills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            if (gi < NB - 1) begin : g_mid
                assign shifted[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
            end else begin : g_top
                assign shifted[gi*8 +: 8] = 8'h00;
            end
        end
    endgenerate

    // Pixel storage has no reset; reset empties it by clearing the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= {nbytes_in, in_pixel_i};
        end
    end

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        shift_next    = shift_reg;
        nbytes_next   = nbytes_reg;
        idx_next      = idx_reg;
        overflow_next = overflow_reg || (px_rdy_i && full);
        pop           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!last_byte) begin
                        shift_next = shifted;
                        idx_next   = idx_reg + 2'd1;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            shift_next  = rd_data[MAX_PIXEL_BITS-1:0];
            nbytes_next = rd_data[EW-1 -: 2];
            idx_next    = 2'd0;
            rd_ptr_next = rd_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + {{AW{1'b0}}, 1'b1};
            2'b01:   count_next = count_reg - {{AW{1'b0}}, 1'b1};
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            shift_reg    <= '0;
            nbytes_reg   <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            shift_reg    <= shift_next;
            nbytes_reg   <= nbytes_next;
            idx_reg      <= idx_next;
            overflow_reg <= overflow_next;
        end
    end

    assign byte_valid_o = (state_reg == SEND);
    assign byte_o       = byte_valid_o ? shift_reg[7:0] : 8'h00;
    assign fifo_full_o  = full;
    assign overflow_o   = overflow_reg;
    assign busy_o       = !empty || (state_reg != IDLE);
`ifdef PX_SER_LAST_EN
    assign byte_last_o  = byte_valid_o && last_byte;
`endif

endmodule

// File: tb/tb_px_out_serializer.sv
// Bench for px_out_serializer: directed test-plan scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based byte model of the serializer.
module tb_px_out_serializer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  select_i;
    logic        px_rdy_i;
    logic [23:0] in_pixel_i;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ack_i;
    logic        fifo_full_o;
    logic        overflow_o;
    logic        busy_o;
`ifdef PX_SER_LAST_EN
    logic        byte_last_o;
`endif

    px_out_serializer #(.FIFO_DEPTH(DEPTH), .MAX_PIXEL_BITS(24)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .select_i     (select_i),
        .px_rdy_i     (px_rdy_i),
        .in_pixel_i   (in_pixel_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ack_i   (byte_ack_i),
        .fifo_full_o  (fifo_full_o),
        .overflow_o   (overflow_o),
`ifdef PX_SER_LAST_EN
        .byte_last_o  (byte_last_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: pixels waiting in the FIFO, and bytes still owed for the pixel on the wire.
    logic [23:0] m_pix [$];
    logic [1:0]  m_nb  [$];
    logic [7:0]  m_cur [$];
    bit          m_ovf;

    logic [7:0]  got   [$];
    logic [7:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          was_full;
        logic [23:0] p;
        logic [1:0]  n;
        if (reset_i) begin
            m_pix.delete();
            m_nb.delete();
            m_cur.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (m_pix.size() == DEPTH);
            if (m_cur.size() > 0 && byte_ack_i) void'(m_cur.pop_front());
            if (m_cur.size() == 0 && m_pix.size() > 0) begin
                p = m_pix.pop_front();
                n = m_nb.pop_front();
                for (int k = 0; k < int'(n); k++) m_cur.push_back(p[8*k +: 8]);
            end
            if (px_rdy_i) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                end else begin
                    m_pix.push_back(in_pixel_i);
                    m_nb.push_back((select_i == 2'b11) ? 2'd3 : 2'd1);
                end
            end
        end
    endtask

    task automatic cycle();
        bit exp_valid;
        if (chk_en) begin
            exp_valid = (m_cur.size() > 0);
            chk("valid", 32'(byte_valid_o), 32'(exp_valid));
            if (exp_valid) chk("byte", 32'(byte_o), 32'(m_cur[0]));
            chk("full", 32'(fifo_full_o), 32'(m_pix.size() == DEPTH));
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
            chk("busy", 32'(busy_o), 32'(m_pix.size() > 0 || m_cur.size() > 0));
`ifdef PX_SER_LAST_EN
            chk("last", 32'(byte_last_o), 32'(exp_valid && m_cur.size() == 1));
`endif
            if (byte_valid_o && byte_ack_i && !reset_i) begin
                got.push_back(byte_o);
                $display("xfer byte=%02h t=%0t", byte_o, $time);
            end
        end
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic [1:0] sel,
                         input logic [23:0] pix, input logic ack);
        reset_i    = rst;
        px_rdy_i   = rdy;
        select_i   = sel;
        in_pixel_i = pix;
        byte_ack_i = ack;
        cycle();
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
        end
        got.delete();
    endtask

    initial begin
        reset_i = 1'b1; px_rdy_i = 1'b0; select_i = 2'b00; in_pixel_i = '0; byte_ack_i = 1'b0;
        drive(1, 0, 2'b00, 24'h0, 0);
        drive(1, 0, 2'b00, 24'h0, 0);
        m_pix.delete(); m_nb.delete(); m_cur.delete(); m_ovf = 1'b0;
        chk_en = 1'b1;
        chk("rst_byte", 32'(byte_o), 32'h0);
        chk("rst_valid", 32'(byte_valid_o), 32'h0);
        chk("rst_full", 32'(fifo_full_o), 32'h0);
        chk("rst_ovf", 32'(overflow_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);

        // Bypass pixel, ack high
        drive(0, 1, 2'b11, 24'hA1B2C3, 1);
        drive(0, 0, 2'b11, 24'h0, 1);
        chk("bypass_lat_low", 32'(byte_valid_o), 32'h1);
        repeat (5) drive(0, 0, 2'b11, 24'h0, 1);
        exp_q = {8'hC3, 8'hB2, 8'hA1};
        check_got("bypass");
        chk("bypass_idle", 32'(busy_o), 32'h0);

        // Grayscale, back-to-back strobes
        drive(0, 1, 2'b10, 24'h000055, 1);
        drive(0, 1, 2'b10, 24'h0000AA, 1);
        repeat (4) drive(0, 0, 2'b10, 24'h0, 1);
        exp_q = {8'h55, 8'hAA};
        check_got("gray");

        // Backpressure
        drive(0, 1, 2'b11, 24'h123456, 0);
        drive(0, 0, 2'b11, 24'h0, 0);
        repeat (5) drive(0, 0, 2'b11, 24'h0, 0);
        repeat (4) drive(0, 0, 2'b11, 24'h0, 1);
        exp_q = {8'h56, 8'h34, 8'h12};
        check_got("bp");

        // Overflow
        for (int i = 1; i <= 6; i++) drive(0, 1, 2'b00, 24'(i), 0);
        chk("ovf_full", 32'(fifo_full_o), 32'h1);
        chk("ovf_set", 32'(overflow_o), 32'h1);
        repeat (8) drive(0, 0, 2'b00, 24'h0, 1);
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_got("ovf");
        chk("ovf_sticky", 32'(overflow_o), 32'h1);

        // Mode change while queued
        drive(0, 1, 2'b11, 24'hFFEEDD, 1);
        drive(0, 1, 2'b01, 24'h000077, 1);
        repeat (6) drive(0, 0, 2'b01, 24'h0, 1);
        exp_q = {8'hDD, 8'hEE, 8'hFF, 8'h77};
        check_got("mode");

        // Mid-pixel reset after the first byte transfers
        drive(0, 1, 2'b11, 24'hA1B2C3, 1);
        drive(0, 0, 2'b11, 24'h0, 1);
        drive(0, 0, 2'b11, 24'h0, 1);
        drive(1, 0, 2'b11, 24'h0, 0);
        chk("mrst_valid", 32'(byte_valid_o), 32'h0);
        chk("mrst_byte", 32'(byte_o), 32'h0);
        chk("mrst_ovf", 32'(overflow_o), 32'h0);
        chk("mrst_busy", 32'(busy_o), 32'h0);
        repeat (5) drive(0, 0, 2'b11, 24'h0, 1);
        exp_q = {8'hC3};
        check_got("mrst");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4),
                  2'($urandom_range(0, 3)), 24'($urandom), ($urandom_range(0, 9) < 6));
        end
        repeat (16) drive(0, 0, 2'b00, 24'h0, 1);
        chk("rand_drained", 32'(busy_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
